// File: rtl/my_module.sv
// my_module -- three-referee goal / no-goal decision unit.
//
// Each cycle with in_valid=1 the three votes are sampled. One cycle later the
// 2-of-3 majority appears on b, b_valid pulses, and unanimous shows whether all
// three votes agreed. goal_cnt counts accepted goal decisions and saturates.
//
// Optional feature: define MY_MODULE_SPLIT_STATS_EN to build a saturating
// counter of 2-1 split decisions on split_cnt. Without the macro split_cnt is
// tied to zero and no counter is built.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   clr        in   1      synchronous clear of counters only
//   in_valid   in   1      qualifies i0/i1/i2
//   i0,i1,i2   in   1      referee votes (1 = goal)
//   b          out  1      registered majority decision
//   b_valid    out  1      one-cycle strobe, b updated
//   unanimous  out  1      registered: all three votes equal
//   goal_cnt   out  CNT_W  saturating count of accepted goals
//   split_cnt  out  CNT_W  saturating count of 2-1 splits (optional)

module my_module #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             i0,
    input  logic             i1,
    input  logic             i2,
    output logic             b,
    output logic             b_valid,
    output logic             unanimous,
    output logic [CNT_W-1:0] goal_cnt,
    output logic [CNT_W-1:0] split_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic maj3(input logic a, input logic b_in, input logic c);
        return (a & b_in) | (a & c) | (b_in & c);
    endfunction

    function automatic logic all_equal3(input logic a, input logic b_in, input logic c);
        return (a == b_in) && (b_in == c);
    endfunction

    logic             maj_s;
    logic             una_s;
    logic [CNT_W-1:0] goal_next_s;
    logic             b_r;
    logic             b_valid_r;
    logic             unanimous_r;
    logic [CNT_W-1:0] goal_cnt_r;

    // Majority/unanimity of the current sample and next goal count (clr wins).
    always_comb begin
        maj_s       = maj3(i0, i1, i2);
        una_s       = all_equal3(i0, i1, i2);
        goal_next_s = goal_cnt_r;
        if (clr) begin
            goal_next_s = CNT_ZERO;
        end else if (in_valid && maj_s && (goal_cnt_r != CNT_MAX)) begin
            goal_next_s = goal_cnt_r + CNT_ONE;
        end else begin
            goal_next_s = goal_cnt_r;
        end
    end

    // Decision registers: b and unanimous hold while no sample is presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_r         <= 1'b0;
            b_valid_r   <= 1'b0;
            unanimous_r <= 1'b0;
            goal_cnt_r  <= CNT_ZERO;
        end else begin
            b_valid_r  <= in_valid;
            goal_cnt_r <= goal_next_s;
            if (in_valid) begin
                b_r         <= maj_s;
                unanimous_r <= una_s;
            end else begin
                b_r         <= b_r;
                unanimous_r <= unanimous_r;
            end
        end
    end

`ifdef MY_MODULE_SPLIT_STATS_EN
    logic [CNT_W-1:0] split_next_s;
    logic [CNT_W-1:0] split_cnt_r;

    // Next split count: a split is any sample whose votes are not all equal.
    always_comb begin
        split_next_s = split_cnt_r;
        if (clr) begin
            split_next_s = CNT_ZERO;
        end else if (in_valid && !una_s && (split_cnt_r != CNT_MAX)) begin
            split_next_s = split_cnt_r + CNT_ONE;
        end else begin
            split_next_s = split_cnt_r;
        end
    end

    // Split counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            split_cnt_r <= CNT_ZERO;
        end else begin
            split_cnt_r <= split_next_s;
        end
    end

    assign split_cnt = split_cnt_r;
`else
    assign split_cnt = CNT_ZERO;
`endif

    assign b         = b_r;
    assign b_valid   = b_valid_r;
    assign unanimous = unanimous_r;
    assign goal_cnt  = goal_cnt_r;

endmodule

// File: tb/tb_my_module.sv
// Scoreboard bench for my_module (CNT_W=2 so saturation is reachable quickly).
// Stimulus pushes the expected response for each valid sample; a monitor pops
// and compares whenever b_valid is seen. Expected b/unanimous come from
// hand-written vector entries; counters follow a small saturating model.

module tb_my_module;

    localparam int W = 2;
    localparam logic [W-1:0] MAXV = {W{1'b1}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic         in_valid = 1'b0;
    logic         i0 = 1'b0;
    logic         i1 = 1'b0;
    logic         i2 = 1'b0;
    logic         b;
    logic         b_valid;
    logic         unanimous;
    logic [W-1:0] goal_cnt;
    logic [W-1:0] split_cnt;

    typedef struct packed {
        logic         eb;
        logic         eu;
        logic [W-1:0] eg;
        logic [W-1:0] es;
    } exp_t;

    exp_t         sb_q[$];
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] goal_m = '0;
    logic [W-1:0] split_m = '0;

    my_module #(.CNT_W(W)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
        .i0(i0), .i1(i1), .i2(i2),
        .b(b), .b_valid(b_valid), .unanimous(unanimous),
        .goal_cnt(goal_cnt), .split_cnt(split_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented decision against the scoreboard head.
    always @(negedge clk) begin
        if (b_valid === 1'b1) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                check("unexpected_b_valid", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("b", {31'd0, b}, {31'd0, e.eb});
                check("unanimous", {31'd0, unanimous}, {31'd0, e.eu});
                check("goal_cnt", {30'd0, goal_cnt}, {30'd0, e.eg});
                check("split_cnt", {30'd0, split_cnt}, {30'd0, e.es});
            end
        end
    end

    // Drive one cycle; for valid samples push the expected response.
    task automatic send(input logic v, input logic [2:0] votes, input logic c,
                        input logic exp_b, input logic exp_u);
        exp_t e;
        in_valid = v;
        {i0, i1, i2} = votes;
        clr = c;
        if (c) begin
            goal_m  = '0;
            split_m = '0;
        end else begin
            if (v && exp_b && goal_m != MAXV) goal_m = goal_m + 1'b1;
`ifdef MY_MODULE_SPLIT_STATS_EN
            if (v && !exp_u && split_m != MAXV) split_m = split_m + 1'b1;
`endif
        end
        if (v) begin
            e.eb = exp_b;
            e.eu = exp_u;
            e.eg = goal_m;
            e.es = split_m;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr = 1'b0;
    endtask

    // Hand-computed majority / unanimity for 000..111.
    logic [7:0] sweep_b = 8'b1110_1000;  // bit k = b for votes k
    logic [7:0] sweep_u = 8'b1000_0001;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_b", {31'd0, b}, 32'd0);
        check("rst_b_valid", {31'd0, b_valid}, 32'd0);
        check("rst_unanimous", {31'd0, unanimous}, 32'd0);
        check("rst_goal", {30'd0, goal_cnt}, 32'd0);
        check("rst_split", {30'd0, split_cnt}, 32'd0);
        rst = 1'b0;

        // Exhaustive sweep, one combination per cycle.
        for (int k = 0; k < 8; k++) begin
            send(1'b1, 3'(k), 1'b0, sweep_b[k], sweep_u[k]);
        end

        // Hold: sample 110 then an invalid 001.
        send(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
        send(1'b1, 3'b110, 1'b0, 1'b1, 1'b0);
        send(1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
        check("hold_b", {31'd0, b}, 32'd1);
        check("hold_b_valid", {31'd0, b_valid}, 32'd0);
        check("hold_unanimous", {31'd0, unanimous}, 32'd0);

        // Saturation: 111 for 5 cycles -> 1,2,3,3,3.
        send(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
        repeat (5) send(1'b1, 3'b111, 1'b0, 1'b1, 1'b1);

        // Clear beats simultaneous increment.
        send(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
        repeat (2) send(1'b1, 3'b111, 1'b0, 1'b1, 1'b1);
        send(1'b1, 3'b111, 1'b1, 1'b1, 1'b1);

        // Split statistics: 011, 100, 111.
        send(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
        send(1'b1, 3'b011, 1'b0, 1'b1, 1'b0);
        send(1'b1, 3'b100, 1'b0, 1'b0, 1'b0);
        send(1'b1, 3'b111, 1'b0, 1'b1, 1'b1);
`ifdef MY_MODULE_SPLIT_STATS_EN
        check("split_total", {30'd0, split_cnt}, 32'd2);
`else
        check("split_total", {30'd0, split_cnt}, 32'd0);
`endif

        // Reach goal_cnt=3 with b=1, then assert reset between edges.
        send(1'b1, 3'b111, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        check("pre_rst_goal", {30'd0, goal_cnt}, 32'd3);
        in_valid = 1'b1;
        {i0, i1, i2} = 3'b111;
        rst = 1'b1;
        #1;
        check("arst_b", {31'd0, b}, 32'd0);
        check("arst_unanimous", {31'd0, unanimous}, 32'd0);
        check("arst_goal", {30'd0, goal_cnt}, 32'd0);
        check("arst_split", {30'd0, split_cnt}, 32'd0);
        check("arst_b_valid", {31'd0, b_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_discard_b", {31'd0, b}, 32'd0);
        check("rst_discard_goal", {30'd0, goal_cnt}, 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        goal_m  = '0;
        split_m = '0;

        // Resume after reset.
        send(1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
        send(1'b1, 3'b101, 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
